reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised successor of the single-output reset generator.
- Combines a power-on reset, a synchronised external active-low reset, a soft-reset mask and a vector of internal reset requests into one reset event.
- After each event it holds all reset outputs for a minimum time, then releases NUM_OUTPUTS reset domains one stage at a time.
- Records which sources caused the most recent resets in sticky cause flags. Sits at the top of the core, between the board reset pin and every clock-domain reset consumer on clk.

Parameters:
- NUM_INT, default 2: width of the int_reset request vector (>=1).
- NUM_OUTPUTS, default 3: number of staged reset outputs (>=1).
- HOLD_CYCLES, default 4095: cycles all outputs stay asserted before stage 0 releases (>=1).
- STAGE_CYCLES, default 16: cycles between consecutive stage releases (>=1).
- SYNC_STAGES, default 3: flops in the ext_reset_n synchroniser (>=2).

Ports:
- clk, input, 1: sole clock.
- reset, input, 1: synchronous, active-high sequencer reset (power-on).
- ext_reset_n, input, 1: asynchronous external reset, active low.
- soft_reset, input, 1: while high, ext_reset_n falling edges are ignored.
- int_reset, input, NUM_INT: level internal reset requests, one per source.
- cause_clr, input, 1: single-cycle clear of the cause flags.
- rst_out, output, NUM_OUTPUTS: active-high domain resets; bit 0 releases first.
- busy, output, 1: high whenever state is not RUN.
- cause, output, NUM_INT+2: sticky flags {int[NUM_INT-1:0], ext, por}; bit 0 = por.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=ASSERT, counter=0, stage=0.
  - rst_out = all ones, busy=1.
  - cause = only por set.
  - Synchroniser and edge flops load 0.
- Synchroniser and edge detect:
  - ext_reset_n passes through SYNC_STAGES flops, then one delay flop.
  - ext_edge = (delay==1 && sync_out==0).
  - Latency from pin to ext_edge is SYNC_STAGES+1 cycles.
  - A pin held low produces exactly one edge.
- Trigger: trig = (ext_edge && !soft_reset) || |int_reset.
  - soft_reset does not mask int_reset.
- Trigger handling: any cycle with trig=1, in any state, produces at the next edge:
  - state=ASSERT, counter=0, stage=0, rst_out = all ones.
  - cause |= {int_reset, ext_edge && !soft_reset, 0}.
- Holding: while any int_reset bit stays high, the counter stays at 0, so the hold time is measured from the request's falling edge.
- ASSERT state:
  - Counter increments each cycle with no trigger.
  - In the cycle counter==HOLD_CYCLES-1, the next state is:
    - NUM_OUTPUTS==1: RUN, rst_out[0]=0.
    - Otherwise: RELEASE, rst_out[0]=0, stage=1, counter=0.
  - Result: with no retrigger, rst_out[0] falls exactly HOLD_CYCLES cycles after ASSERT is entered.
- RELEASE state:
  - Counter increments.
  - In the cycle counter==STAGE_CYCLES-1, rst_out[stage] clears and counter=0.
  - If stage==NUM_OUTPUTS-1, state becomes RUN. Otherwise stage increments.
  - Result: rst_out[k] falls HOLD_CYCLES + k*STAGE_CYCLES cycles after ASSERT entry.
- RUN state: all rst_out=0, busy=0, counter frozen. Only a trigger leaves RUN.
- Output encoding: rst_out is monotonic during a sequence: bit k is never low while bit j<k... is high (i.e. higher bits release no earlier than lower bits).
- Counter: width = clog2(max(HOLD_CYCLES,STAGE_CYCLES)+1). It never exceeds its terminal value and has no wrap.
- Stage index: width = clog2(NUM_OUTPUTS) (minimum 1).
- cause_clr: clears all cause flags at the next edge. If a trigger occurs in the same cycle, the new trigger's bits are set; the cause_clr clear of other bits still applies.
- reset priority: reset overrides trig and cause_clr.
- Retrigger mid-RELEASE: already-released domains re-assert on the next edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Power-on, with defaults overridden to HOLD=8, STAGE=4, NUM_OUTPUTS=3, SYNC_STAGES=2:
  - Stimulus: reset high 2 cycles, then low.
  - Required: rst_out=111 for 8 cycles, 110 for 4, 100 for 4, then 000. busy falls with the last bit. cause=0001.
- External edge:
  - Stimulus: in RUN, drive ext_reset_n low for 20 cycles.
  - Required: rst_out=111 three cycles after the pin falls, and one sequence only. The release timing matches the power-on case. cause bit1 set.
- Masked external edge:
  - Stimulus: soft_reset=1 during the ext_reset_n falling edge.
  - Required: rst_out stays 000, busy stays 0, cause unchanged.
- Held internal request:
  - Stimulus: int_reset[1] high for 30 cycles during RUN.
  - Required: rst_out=111 throughout, and rst_out[0] falls 8 cycles after int_reset[1] drops. cause bit3 set.
- Retrigger mid-release:
  - Stimulus: pulse int_reset[0] when rst_out=100.
  - Required: rst_out=111 on the next cycle, followed by a full new sequence from HOLD.
- cause_clr collision:
  - Stimulus: with cause=0011, assert cause_clr and int_reset[0] in the same cycle.
  - Required: cause=0100 on the next cycle.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: merges power-on, synchronised external, and internal reset
// requests into one event, holds every domain, then releases the domains in order.
module reset_sequencer #(
  parameter int NUM_INT      = 2,
  parameter int NUM_OUTPUTS  = 3,
  parameter int HOLD_CYCLES  = 4095,
  parameter int STAGE_CYCLES = 16,
  parameter int SYNC_STAGES  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ext_reset_n,
  input  logic                   soft_reset,
  input  logic [NUM_INT-1:0]     int_reset,
  input  logic                   cause_clr,
  output logic [NUM_OUTPUTS-1:0] rst_out,
  output logic                   busy,
  output logic [NUM_INT+1:0]     cause
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE_CYCLES - 1);
  localparam logic [SW-1:0] STAGE_FINAL = SW'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [SW-1:0]          stage;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   ext_dly;
  logic                   ext_edge;
  logic                   ext_trig;
  logic                   trig;

  // Falling edge of the synchronised pin; a pin held low yields a single pulse.
  assign ext_edge = ext_dly & ~sync_chain[SYNC_STAGES-1];
  assign ext_trig = ext_edge & ~soft_reset;
  assign trig     = ext_trig | (|int_reset);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ASSERT;
      count      <= '0;
      stage      <= '0;
      rst_out    <= '1;
      busy       <= 1'b1;
      cause      <= {{(NUM_INT + 1){1'b0}}, 1'b1};
      sync_chain <= '0;
      ext_dly    <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], ext_reset_n};
      ext_dly    <= sync_chain[SYNC_STAGES-1];
      // A clear and a fresh trigger in the same cycle keep only the new trigger's bits.
      cause      <= (cause_clr ? '0 : cause) | {int_reset, ext_trig, 1'b0};

      if (trig) begin
        state   <= ASSERT;
        count   <= '0;
        stage   <= '0;
        rst_out <= '1;
        busy    <= 1'b1;
      end else begin
        case (state)
          ASSERT: begin
            if (count == HOLD_LAST) begin
              rst_out[0] <= 1'b0;
              count      <= '0;
              if (NUM_OUTPUTS == 1) begin
                state <= RUN;
                busy  <= 1'b0;
              end else begin
                state <= RELEASE;
                stage <= SW'(1);
              end
            end else begin
              count <= count + 1'b1;
            end
          end
          RELEASE: begin
            if (count == STAGE_LAST) begin
              rst_out[stage] <= 1'b0;
              count          <= '0;
              if (stage == STAGE_FINAL) begin
                state <= RUN;
                busy  <= 1'b0;
              end else begin
                stage <= stage + 1'b1;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
          default: begin
            rst_out <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with short timing parameters; directed scenarios plus a
// randomized run checked against an elapsed-time model of the release schedule.
module tb_reset_sequencer;

  localparam int NI = 2;
  localparam int NO = 3;
  localparam int H  = 8;
  localparam int S  = 4;
  localparam int SY = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ext_reset_n;
  logic          soft_reset;
  logic [NI-1:0] int_reset;
  logic          cause_clr;
  logic [NO-1:0] rst_out;
  logic          busy;
  logic [NI+1:0] cause;

  int checks = 0;
  int passed = 0;

  reset_sequencer #(
    .NUM_INT(NI), .NUM_OUTPUTS(NO), .HOLD_CYCLES(H), .STAGE_CYCLES(S), .SYNC_STAGES(SY)
  ) dut (
    .clk(clk), .reset(reset), .ext_reset_n(ext_reset_n), .soft_reset(soft_reset),
    .int_reset(int_reset), .cause_clr(cause_clr), .rst_out(rst_out), .busy(busy),
    .cause(cause)
  );

  always #5 clk = ~clk;

  // Reference model: cycles elapsed since the last reset event, plus pin history.
  int            since;
  logic [NI+1:0] m_cause;
  logic          pin_hist [0:SY];
  logic          m_ext;
  logic          m_trig;

  always @(posedge clk) begin
    if (reset) begin
      since   = 0;
      m_cause = 4'b0001;
      for (int i = 0; i <= SY; i++) pin_hist[i] = 1'b0;
    end else begin
      m_ext   = pin_hist[SY] && !pin_hist[SY-1];
      m_trig  = (m_ext && !soft_reset) || (|int_reset);
      m_cause = (cause_clr ? '0 : m_cause) | {int_reset, m_ext && !soft_reset, 1'b0};
      since   = m_trig ? 0 : ((since < 100000) ? since + 1 : since);
      for (int i = SY; i > 0; i--) pin_hist[i] = pin_hist[i-1];
      pin_hist[0] = ext_reset_n;
    end
  end

  function automatic logic [NO-1:0] exp_rst(input int t);
    logic [NO-1:0] r;
    for (int k = 0; k < NO; k++) r[k] = (t < H + k * S);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (rst_out !== 3'b111) $display("FAIL reset_rst_out got %b expected %b", rst_out, 3'b111);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy got %b expected 1", busy);
    else passed++;
    checks++;
    if (cause !== 4'b0001) $display("FAIL reset_cause got %b expected 0001", cause);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_power_on();
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++;
      if (rst_out !== exp_rst(j)) $display("FAIL pwr_rst_out cyc %0d got %b expected %b", j, rst_out, exp_rst(j));
      else passed++;
      checks++;
      if (busy !== (j < H + (NO - 1) * S)) $display("FAIL pwr_busy cyc %0d got %b", j, busy);
      else passed++;
    end
    checks++;
    if (cause !== 4'b0001) $display("FAIL pwr_cause got %b expected 0001", cause);
    else passed++;
  endtask

  task automatic test_ext_edge();
    int rises = 0;
    logic [NO-1:0] prev;
    prev = rst_out;
    ext_reset_n = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (j == 21) ext_reset_n = 1'b1;
      tick();
      if (prev == 3'b000 && rst_out == 3'b111) rises++;
      prev = rst_out;
      if (j < 3) begin
        checks++;
        if (rst_out !== 3'b000) $display("FAIL ext_latency cyc %0d got %b expected 000", j, rst_out);
        else passed++;
      end else begin
        checks++;
        if (rst_out !== exp_rst(j - 3)) $display("FAIL ext_rst_out cyc %0d got %b expected %b", j, rst_out, exp_rst(j - 3));
        else passed++;
      end
    end
    checks++;
    if (rises !== 1) $display("FAIL ext_single_seq got %0d sequences expected 1", rises);
    else passed++;
    checks++;
    if (cause !== 4'b0011) $display("FAIL ext_cause got %b expected 0011", cause);
    else passed++;
  endtask

  task automatic test_masked_ext();
    soft_reset  = 1'b1;
    ext_reset_n = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      if (j == 8) ext_reset_n = 1'b1;
      tick();
      checks++;
      if (rst_out !== 3'b000 || busy !== 1'b0)
        $display("FAIL masked_out cyc %0d got rst_out=%b busy=%b expected 000/0", j, rst_out, busy);
      else passed++;
    end
    soft_reset = 1'b0;
    checks++;
    if (cause !== 4'b0011) $display("FAIL masked_cause got %b expected 0011", cause);
    else passed++;
  endtask

  task automatic test_held_int();
    int_reset = 2'b10;
    for (int j = 1; j <= 30; j++) begin
      tick();
      checks++;
      if (rst_out !== 3'b111) $display("FAIL held_rst_out cyc %0d got %b expected 111", j, rst_out);
      else passed++;
    end
    int_reset = 2'b00;
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++;
      if (rst_out !== exp_rst(j)) $display("FAIL held_release cyc %0d got %b expected %b", j, rst_out, exp_rst(j));
      else passed++;
    end
    checks++;
    if (cause[3] !== 1'b1) $display("FAIL held_cause got %b expected bit3 set", cause);
    else passed++;
  endtask

  task automatic test_retrigger();
    bit found = 0;
    int_reset = 2'b01;
    tick();
    int_reset = 2'b00;
    for (int j = 0; j < 50 && !found; j++) begin
      tick();
      if (rst_out == 3'b100) found = 1;
    end
    checks++;
    if (!found) $display("FAIL retrig_wait got %b expected 100 within 50 cycles", rst_out);
    else passed++;
    int_reset = 2'b01;
    tick();
    int_reset = 2'b00;
    checks++;
    if (rst_out !== 3'b111) $display("FAIL retrig_reassert got %b expected 111", rst_out);
    else passed++;
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++;
      if (rst_out !== exp_rst(j)) $display("FAIL retrig_seq cyc %0d got %b expected %b", j, rst_out, exp_rst(j));
      else passed++;
    end
  endtask

  task automatic test_cause_clr();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 20; j++) tick();
    ext_reset_n = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    checks++;
    if (cause !== 4'b0011) $display("FAIL clr_setup got %b expected 0011", cause);
    else passed++;
    cause_clr = 1'b1;
    int_reset = 2'b01;
    tick();
    cause_clr = 1'b0;
    int_reset = 2'b00;
    ext_reset_n = 1'b1;
    checks++;
    if (cause !== 4'b0100) $display("FAIL clr_collision got %b expected 0100", cause);
    else passed++;
    for (int j = 0; j < 20; j++) tick();
  endtask

  task automatic test_random();
    for (int j = 0; j < 600; j++) begin
      reset      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) ext_reset_n = ~ext_reset_n;
      if ($urandom_range(0, 7) == 0) soft_reset = $urandom_range(0, 1);
      for (int b = 0; b < NI; b++) int_reset[b] = ($urandom_range(0, 39) == 0);
      cause_clr  = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (rst_out !== exp_rst(since)) $display("FAIL rand_rst_out cyc %0d got %b expected %b", j, rst_out, exp_rst(since));
      else passed++;
      checks++;
      if (busy !== (since < H + (NO - 1) * S)) $display("FAIL rand_busy cyc %0d got %b", j, busy);
      else passed++;
      checks++;
      if (cause !== m_cause) $display("FAIL rand_cause cyc %0d got %b expected %b", j, cause, m_cause);
      else passed++;
    end
    reset = 1'b0; int_reset = '0; cause_clr = 1'b0; soft_reset = 1'b0; ext_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; ext_reset_n = 1'b1; soft_reset = 1'b0; int_reset = '0; cause_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_power_on();
    test_ext_edge();
    test_masked_ext();
    test_held_int();
    test_retrigger();
    test_cause_clr();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
